// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic weight loader.
package sa_pkg;

  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned DEF_BW_WET = 8;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StDone
  } loader_state_e;

endpackage

// File: rtl/systolic_weight_loader_if.sv
// Weight-row stream: one row of COLS weights per valid/ready beat.
interface systolic_weight_loader_if
  import sa_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned BW_WET = DEF_BW_WET
);

  logic                   wet_valid;
  logic [COLS*BW_WET-1:0] wet_data;
  logic                   wet_ready;

  modport master (
    output wet_valid,
    output wet_data,
    input  wet_ready
  );

  modport slave (
    input  wet_valid,
    input  wet_data,
    output wet_ready
  );

endinterface

// File: rtl/systolic_weight_loader.sv
// Clears all PE weights, then streams ROWS weight rows onto a broadcast bus
// with a one-hot per-row load enable.
module systolic_weight_loader
  import sa_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned BW_WET = DEF_BW_WET
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear_req,
  systolic_weight_loader_if.slave wet,
  output logic [COLS*BW_WET-1:0] wet_out,
  output logic [ROWS-1:0]        row_load_en,
  output logic                   clear_weight,
  output logic                   busy,
  output logic                   loaded
);

  localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CntW-1:0] LastRow = CntW'(ROWS - 1);

  loader_state_e   state_q;
  logic [CntW-1:0] row_cnt_q;
  // Remembers whether the current CLEAR came from start (load follows) or clear_req.
  logic            load_pending_q;
  logic            beat_accept;

  // Ready depends only on state and clear_req so an abort never races a beat.
  assign wet.wet_ready = (state_q == StLoad) && !clear_req;
  assign beat_accept   = wet.wet_valid && wet.wet_ready;

  // State-decoded status outputs.
  assign clear_weight = (state_q == StClear);
  assign busy         = (state_q == StClear) || (state_q == StLoad);
  assign loaded       = (state_q == StDone);

  // FSM, row counter and registered weight bus / row enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      row_cnt_q      <= '0;
      load_pending_q <= 1'b0;
      wet_out        <= '0;
      row_load_en    <= '0;
    end else begin
      row_load_en <= '0;
      if (clear_req) begin
        state_q        <= StClear;
        load_pending_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start) begin
              state_q        <= StClear;
              load_pending_q <= 1'b1;
            end
          end
          StClear: begin
            load_pending_q <= 1'b0;
            row_cnt_q      <= '0;
            state_q        <= load_pending_q ? StLoad : StIdle;
          end
          StLoad: begin
            if (beat_accept) begin
              wet_out     <= wet.wet_data;
              row_load_en <= ROWS'(1) << row_cnt_q;
              if (row_cnt_q == LastRow) begin
                state_q <= StDone;
              end else begin
                row_cnt_q <= row_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
